// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Holds word width, nop/miss words, base address and the fetch bundle type.
package fetch_pkg;

    localparam int          INSTR_W       = 32;
    localparam int          ISSUE_MAX     = 4;
    localparam logic [31:0] NOP_WORD      = 32'h38000000;
    localparam logic [31:0] DEF_MISS_WORD = 32'hFFFFFFFF;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h00400000;

    typedef struct packed {
        logic [ISSUE_MAX-1:0][INSTR_W-1:0] instr;
        logic [ISSUE_MAX-1:0]              slot_valid;
        logic                              fault;
    } fetch_bundle_t;

    // Word index of slot k, widened so it can never wrap back to word 0.
    function automatic logic [32:0] slot_index(
        input logic [31:0] offset,
        input int unsigned k
    );
        return {3'b000, offset[31:2]} + 33'(k);
    endfunction

endpackage

// File: rtl/imem_ram_1w_nr.sv
// Instruction RAM: one write port, RD_PORTS synchronous read ports.
// Ports: we/waddr/wdata write; re/raddr read; rdata registered, read-old.
module imem_ram_1w_nr
    import fetch_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int RD_PORTS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 we,
    input  logic [$clog2(DEPTH)-1:0]             waddr,
    input  logic [INSTR_W-1:0]                   wdata,
    input  logic                                 re,
    input  logic [RD_PORTS-1:0][$clog2(DEPTH)-1:0] raddr,
    output logic [RD_PORTS-1:0][INSTR_W-1:0]     rdata
);

    // Words are stored XOR NOP_WORD, so an untouched (all-zero) array
    // reads back as nop without needing an init block.
    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata ^ NOP_WORD;
        end
    end

    // Read data register loads only on an accepted fetch, so the held
    // bundle stays stable during a stall even if the word is rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            for (int k = 0; k < RD_PORTS; k++) begin
                rdata[k] <= mem[raddr[k]] ^ NOP_WORD;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Registered multi-slot instruction memory with valid/ready response.
// Ports: req_* fetch request, rsp_* bundle out, flush, prog_* image load.
module instr_fetch_mem
    import fetch_pkg::*;
#(
    parameter int          ISSUE_W     = 2,
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [31:0] MISS_WORD   = DEF_MISS_WORD
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [31:0]                      req_pc,
    input  logic                             flush,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [INSTR_W*ISSUE_W-1:0]       rsp_instr,
    output logic [ISSUE_W-1:0]               rsp_slot_valid,
    output logic                             rsp_fault,
    input  logic                             prog_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0]   prog_addr,
    input  logic [31:0]                      prog_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]                     pc_off;
    logic                            pc_below;
    logic                            pc_aligned;
    logic [ISSUE_W-1:0]              slot_ok;
    logic [ISSUE_W-1:0][AW-1:0]      rd_addr;
    logic [ISSUE_W-1:0][INSTR_W-1:0] rd_data;
    logic                            accept;

    logic                            valid_q;
    logic [ISSUE_W-1:0]              slot_valid_q;
    logic [ISSUE_W-1:0]              miss_q;
    logic                            fault_q;

    fetch_bundle_t                   rsp_b;
    logic                            unused_bits;

    assign pc_off     = req_pc - BASE_ADDR;
    assign pc_below   = req_pc < BASE_ADDR;
    assign pc_aligned = req_pc[1:0] == 2'b00;

    always_comb begin
        slot_ok = '0;
        rd_addr = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            logic [32:0] widx;
            widx       = slot_index(pc_off, k);
            slot_ok[k] = pc_aligned & ~pc_below
                       & (widx < 33'(DEPTH_WORDS));
            rd_addr[k] = widx[AW-1:0];
        end
    end

    assign req_ready = ~valid_q | rsp_ready;
    assign accept    = req_valid & req_ready & ~flush;

    imem_ram_1w_nr #(
        .DEPTH    (DEPTH_WORDS),
        .RD_PORTS (ISSUE_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (accept),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // miss_q marks slots to replace with MISS_WORD; it resets to 0 so the
    // cleared read register shows up as all-zero instr during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            slot_valid_q <= '0;
            miss_q       <= '0;
            fault_q      <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q      <= 1'b1;
            slot_valid_q <= slot_ok;
            miss_q       <= ~slot_ok;
            fault_q      <= ~slot_ok[0];
        end else if (rsp_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_comb begin
        rsp_b       = '0;
        rsp_b.fault = fault_q;
        for (int k = 0; k < ISSUE_MAX; k++) begin
            rsp_b.instr[k] = MISS_WORD;
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            rsp_b.instr[k]      = miss_q[k] ? MISS_WORD : rd_data[k];
            rsp_b.slot_valid[k] = slot_valid_q[k];
        end
    end

    assign rsp_valid      = valid_q;
    assign rsp_instr      = rsp_b.instr[ISSUE_W-1:0];
    assign rsp_slot_valid = rsp_b.slot_valid[ISSUE_W-1:0];
    assign rsp_fault      = rsp_b.fault;

    assign unused_bits = ^{rsp_b, pc_off[1:0]};

endmodule
